clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
- Runtime-programmable integer clock divider. Generates a divided clock, `clock_out`, and a one-cycle period-start pulse, `tick`, from `clock_in`.
- Divide ratio is set by `div_ratio` and updated glitch-free at period boundaries only.
- Used by video/tracking pipeline blocks that need pixel- or sample-rate clocks and clock-enables derived from the system clock.
- With `DEFAULT_DIV=4` and `div_ratio` tied to 4, output is identical to the legacy fixed divide-by-4 toggle divider.

Parameters:
- CNT_W, 16, width of divide-ratio input and internal period counter.
- DEFAULT_DIV, 4, ratio loaded at reset, before the first boundary; must be in 2..2^CNT_W-1.

Ports:
- clock_in  input  1  system clock; all logic on rising edge.
- aresetn  input  1  reset, synchronous, active-low.
- enable  input  1  run when high; hold/re-arm when low.
- div_ratio  input  CNT_W  requested divide ratio N (output period = N clock_in cycles).
- clock_out  output  1  divided clock, registered.
- tick  output  1  high for exactly one clock_in cycle at the start of each output period (coincident with clock_out rising).
- cur_ratio  output  CNT_W  ratio currently in effect (N_act).

Behaviour:
- State: `cnt` (CNT_W), `N_act` (CNT_W), `hi_len` (CNT_W), all registered.
- Clamp: effective request `R` = `div_ratio` if `div_ratio` >= 2, else 2. Ratios 0 and 1 are never applied.
- Reset (`aresetn`=0 at edge):
  - `N_act`=DEFAULT_DIV; `hi_len`=DEFAULT_DIV>>1; `cnt`=DEFAULT_DIV-1.
  - `clock_out`=0; `tick`=0; `cur_ratio`=DEFAULT_DIV.
  - Reset has priority over `enable` and applies mid-period with no partial-period completion.
- Enabled edge, terminal (`cnt`==`N_act`-1):
  - `N_act`<=R; `hi_len`<=R>>1; `cnt`<=0.
  - `clock_out`<=1; `tick`<=1.
- Enabled edge, non-terminal:
  - `cnt`<=`cnt`+1.
  - `clock_out`<=(`cnt`+1 < `hi_len`); `tick`<=0.
- Result per period of N cycles:
  - `clock_out` high for N>>1 cycles, low for N-(N>>1). Odd N gives a short high phase.
  - Max N = 2^CNT_W-1; `cnt` never wraps past `N_act`-1.
- First period: because reset pre-loads `cnt`=`N_act`-1, the first enabled edge after reset is a boundary.
  - `tick`=1 and `clock_out`=1 one cycle after `enable` is first sampled high.
  - `div_ratio` is sampled at that edge.
- `enable`=0 at edge:
  - `cnt`<=`N_act`-1; `clock_out`<=0; `tick`<=0; `N_act`/`hi_len` hold.
  - On re-enable, a fresh period starts with the same one-cycle latency.
  - Dropping `enable` mid-high-phase truncates the pulse; this is an accepted, documented behaviour.
- Ratio change: `div_ratio` is sampled only on the terminal edge. Changes mid-period have no effect until the current period completes, so no runt pulses result.
- `cur_ratio` = `N_act`.
- Simultaneous terminal and `enable` falling: the `enable`=0 rule wins and the ratio is not reloaded.

Optional Feature:
- Macro: CLOCK_DIVIDER_PROG_DUTY_EN.
- Defined:
  - Adds input port `duty_hi` (CNT_W), the requested high-phase length H.
  - Latched at the terminal edge together with `div_ratio`.
  - `hi_len`<=H clamped to the range [1, R-1].
  - `tick` and period behaviour are unchanged.
- Undefined:
  - Port is absent; `hi_len` is always R>>1.
  - Reset value of `hi_len` is DEFAULT_DIV>>1 in both builds.

Test Plan:
- Legacy equivalence: reset 3 cycles, `enable`=1, `div_ratio`=4. Expect `clock_out` pattern 1100 repeating; `tick` every 4th cycle; first `tick` 1 cycle after reset release; `cur_ratio`=4.
- Odd ratio: `div_ratio`=5. Expect high 2 / low 3 cycles, period 5; `tick` once per 5 cycles.
- Mid-period change: running at N=8, set `div_ratio`=3 at `cnt`=2. Expect the current period to complete at 8 cycles, then 3-cycle periods (high 1 / low 2); `cur_ratio` changes 8 -> 3 at the boundary edge; no runt pulse.
- Clamp: `div_ratio`=0, then 1. Expect N_act=2 and `clock_out` toggling 1010; `cur_ratio`=2.
- Enable gating: N=6, drop `enable` at `cnt`=1 (`clock_out`=1). Next cycle `clock_out`=0 and `tick`=0 while held. On re-enable, `tick`=1 and `clock_out`=1 after 1 cycle, then a full 3/3 period.
- Reset mid-operation: N=10, assert `aresetn`=0 at `cnt`=7. Expect `clock_out`=0, `tick`=0, `cur_ratio`=4 at the next edge. With CLOCK_DIVIDER_PROG_DUTY_EN build, N=10, `duty_hi`=7 gives high 7 / low 3; `duty_hi`=0 clamps to high 1.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider: divided clock, period-start tick and active ratio.
// Optional CLOCK_DIVIDER_PROG_DUTY_EN adds a programmable high-phase length (duty_hi).
module clock_divider_prog #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clock_in,
    input  logic             aresetn,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_ratio,
`ifdef CLOCK_DIVIDER_PROG_DUTY_EN
    input  logic [CNT_W-1:0] duty_hi,
`endif
    output logic             clock_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_ratio
);

    localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_HI    = CNT_W'(DEFAULT_DIV >> 1);
    localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_RATIO = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] n_act_q,  n_act_d;
    logic [CNT_W-1:0] hi_len_q, hi_len_d;
    logic             clock_out_q, clock_out_d;
    logic             tick_q,      tick_d;

    logic [CNT_W-1:0] req_ratio_c;
    logic [CNT_W-1:0] req_hi_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             terminal_c;

    // Ratios below 2 cannot form a period with both phases, so they are lifted to 2.
    assign req_ratio_c = (div_ratio < MIN_RATIO) ? MIN_RATIO : div_ratio;

`ifdef CLOCK_DIVIDER_PROG_DUTY_EN
    // Keep at least one high and one low cycle per period.
    always_comb begin
        req_hi_c = duty_hi;
        if (duty_hi == '0) begin
            req_hi_c = ONE;
        end else if (duty_hi > (req_ratio_c - ONE)) begin
            req_hi_c = req_ratio_c - ONE;
        end
    end
`else
    assign req_hi_c = req_ratio_c >> 1;
`endif

    assign cnt_inc_c  = cnt_q + ONE;
    assign terminal_c = (cnt_q == (n_act_q - ONE));

    // Period counter; new ratio is only taken on the terminal edge.
    always_comb begin
        cnt_d       = cnt_q;
        n_act_d     = n_act_q;
        hi_len_d    = hi_len_q;
        clock_out_d = 1'b0;
        tick_d      = 1'b0;
        if (!enable) begin
            cnt_d = n_act_q - ONE;
        end else if (terminal_c) begin
            n_act_d     = req_ratio_c;
            hi_len_d    = req_hi_c;
            cnt_d       = '0;
            clock_out_d = 1'b1;
            tick_d      = 1'b1;
        end else begin
            cnt_d       = cnt_inc_c;
            clock_out_d = (cnt_inc_c < hi_len_q);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!aresetn) begin
            cnt_q       <= RST_CNT;
            n_act_q     <= RST_RATIO;
            hi_len_q    <= RST_HI;
            clock_out_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            n_act_q     <= n_act_d;
            hi_len_q    <= hi_len_d;
            clock_out_q <= clock_out_d;
            tick_q      <= tick_d;
        end
    end

    assign clock_out = clock_out_q;
    assign tick      = tick_q;
    assign cur_ratio = n_act_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: vector table, corner sequences and random run vs a period-queue model.
module tb_clock_divider_prog;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEF   = 4;

    logic             clock_in = 1'b0;
    logic             aresetn  = 1'b0;
    logic             enable   = 1'b0;
    logic [CNT_W-1:0] div_ratio = 16'd4;
    logic [CNT_W-1:0] duty_hi   = 16'd2;
    logic             clock_out;
    logic             tick;
    logic [CNT_W-1:0] cur_ratio;

    int checks = 0;
    int errors = 0;

    clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clock_in  (clock_in),
        .aresetn   (aresetn),
        .enable    (enable),
        .div_ratio (div_ratio),
`ifdef CLOCK_DIVIDER_PROG_DUTY_EN
        .duty_hi   (duty_hi),
`endif
        .clock_out (clock_out),
        .tick      (tick),
        .cur_ratio (cur_ratio)
    );

    always #5 clock_in = ~clock_in;

    // Model: at each period start, the whole period's (tick, clock_out) sequence is queued.
    bit          mq_co[$];
    bit          mq_tk[$];
    int          m_n   = DEF;
    bit          exp_co;
    bit          exp_tk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int r;
        int h;
        if (!aresetn) begin
            mq_co.delete(); mq_tk.delete();
            m_n = DEF; exp_co = 0; exp_tk = 0;
        end else if (!enable) begin
            mq_co.delete(); mq_tk.delete();
            exp_co = 0; exp_tk = 0;
        end else begin
            if (mq_co.size() == 0) begin
                r = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                h = r / 2;
`ifdef CLOCK_DIVIDER_PROG_DUTY_EN
                h = int'(duty_hi);
                if (h < 1) h = 1;
                if (h > r - 1) h = r - 1;
`endif
                m_n = r;
                for (int k = 0; k < r; k++) begin
                    mq_tk.push_back(k == 0);
                    mq_co.push_back(k < h);
                end
            end
            exp_co = mq_co.pop_front();
            exp_tk = mq_tk.pop_front();
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [CNT_W-1:0] ratio,
                        input logic [CNT_W-1:0] duty);
        @(negedge clock_in);
        aresetn = rst; enable = en; div_ratio = ratio; duty_hi = duty;
        @(posedge clock_in);
        model_edge();
        #1;
        chk("model_clock_out", int'(clock_out), int'(exp_co));
        chk("model_tick",      int'(tick),      int'(exp_tk));
        chk("model_cur_ratio", int'(cur_ratio), m_n);
    endtask

    // Duty follows ratio/2 so hand expectations hold in both builds.
    task automatic step_r(input logic rst, input logic en, input logic [CNT_W-1:0] ratio);
        step(rst, en, ratio, ratio >> 1);
    endtask

    typedef struct {
        logic             rst;
        logic             en;
        logic [CNT_W-1:0] ratio;
        logic             co;
        logic             tk;
        logic [CNT_W-1:0] cur;
    } vec_t;

    vec_t vecs[$];
    int   hi_cnt;
    int   tk_cnt;
    logic en_r;
    logic [CNT_W-1:0] rnd_ratio;

    initial begin
        // Legacy divide-by-4, reset priority over enable, then clamp of 0 and 1.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 16'd4});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, 1'b1, 16'd4, (i % 4) < 2, (i % 4) == 0, 16'd4});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b1, 1'b1, 16'd0, (i % 2) == 0, (i % 2) == 0, 16'd2});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b1, 1'b1, 16'd1, (i % 2) == 0, (i % 2) == 0, 16'd2});

        foreach (vecs[i]) begin
            step_r(vecs[i].rst, vecs[i].en, vecs[i].ratio);
            chk($sformatf("vec%0d_clock_out", i), int'(clock_out), int'(vecs[i].co));
            chk($sformatf("vec%0d_tick", i),      int'(tick),      int'(vecs[i].tk));
            chk($sformatf("vec%0d_cur_ratio", i), int'(cur_ratio), int'(vecs[i].cur));
        end

        // Odd ratio 5: 2 high / 3 low, one tick per period.
        step_r(1'b0, 1'b0, 16'd5);
        hi_cnt = 0; tk_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step_r(1'b1, 1'b1, 16'd5);
            hi_cnt += int'(clock_out); tk_cnt += int'(tick);
        end
        chk("odd5_high_cycles", hi_cnt, 4);
        chk("odd5_ticks", tk_cnt, 2);

        // Ratio change at cnt=2 of an 8-cycle period takes effect only at the boundary.
        step_r(1'b0, 1'b0, 16'd8);
        step_r(1'b1, 1'b1, 16'd8);
        step_r(1'b1, 1'b1, 16'd8);
        step_r(1'b1, 1'b1, 16'd8);
        tk_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step_r(1'b1, 1'b1, 16'd3);
            tk_cnt += int'(tick);
        end
        chk("midchg_no_early_tick", tk_cnt, 0);
        chk("midchg_cur_before", int'(cur_ratio), 8);
        step_r(1'b1, 1'b1, 16'd3);
        chk("midchg_boundary_tick", int'(tick), 1);
        chk("midchg_cur_after", int'(cur_ratio), 3);
        step_r(1'b1, 1'b1, 16'd3);
        step_r(1'b1, 1'b1, 16'd3);
        chk("midchg_low_phase", int'(clock_out), 0);
        step_r(1'b1, 1'b1, 16'd3);
        chk("midchg_next_tick", int'(tick), 1);

        // Enable drop at cnt=1 truncates the high phase; re-enable restarts a full period.
        step_r(1'b0, 1'b0, 16'd6);
        step_r(1'b1, 1'b1, 16'd6);
        step_r(1'b1, 1'b1, 16'd6);
        chk("gate_high_before_drop", int'(clock_out), 1);
        step_r(1'b1, 1'b0, 16'd6);
        chk("gate_drop_clock_out", int'(clock_out), 0);
        chk("gate_drop_tick", int'(tick), 0);
        step_r(1'b1, 1'b0, 16'd6);
        chk("gate_hold_cur", int'(cur_ratio), 6);
        hi_cnt = 0; tk_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step_r(1'b1, 1'b1, 16'd6);
            if (i == 0) chk("gate_reenable_tick", int'(tick), 1);
            hi_cnt += int'(clock_out); tk_cnt += int'(tick);
        end
        chk("gate_full_period_high", hi_cnt, 3);
        chk("gate_full_period_ticks", tk_cnt, 1);

        // Reset at cnt=7 of a 10-cycle period.
        step_r(1'b1, 1'b1, 16'd10);
        for (int i = 0; i < 20; i++) begin
            step_r(1'b1, 1'b1, 16'd10);
            if (cur_ratio == 16'd10 && tick) break;
        end
        for (int i = 0; i < 7; i++) step_r(1'b1, 1'b1, 16'd10);
        step_r(1'b0, 1'b1, 16'd10);
        chk("rst_mid_clock_out", int'(clock_out), 0);
        chk("rst_mid_tick", int'(tick), 0);
        chk("rst_mid_cur", int'(cur_ratio), 4);

`ifdef CLOCK_DIVIDER_PROG_DUTY_EN
        // Programmable duty: 7 high of 10, and 0 clamped to 1.
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 16'd10, 16'd7);
            hi_cnt += int'(clock_out);
        end
        chk("duty7_high_cycles", hi_cnt, 7);
        step(1'b0, 1'b0, 16'd10, 16'd0);
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 16'd10, 16'd0);
            hi_cnt += int'(clock_out);
        end
        chk("duty0_high_cycles", hi_cnt, 1);
`endif

        // Random traffic against the model.
        en_r = 1'b1;
        rnd_ratio = 16'd4;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) en_r = ~en_r;
            if ($urandom_range(0, 7) == 0) rnd_ratio = CNT_W'($urandom_range(0, 12));
            step($urandom_range(0, 299) != 0, en_r, rnd_ratio, CNT_W'($urandom_range(0, 14)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
